// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the video timing sequencer.
// Holds the FSM state encoding, default 720p60 timing and width helpers.
// Pure declarations: no logic, no latency, no backpressure.
//
// Contents:
//   state_t          - sequencer state (IDLE, RUN, STOPPING)
//   DEF_*            - default 1280x720 @ 60 Hz timing parameters
//   DEF_H/V_TOTAL    - derived totals for the default timing
//   width_of()       - bit width needed to hold 0..n-1 (never below 1)
package vga_timing_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  // Default 720p60 timing (74.25 MHz pixel clock).
  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_V_ACTIVE = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;
  localparam bit          DEF_HS_POL   = 1'b1;
  localparam bit          DEF_VS_POL   = 1'b1;

  localparam int unsigned DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Width of a counter/index ranging over 0..n-1. A range of one value still
  // gets a 1-bit signal so that no zero-width vectors are ever declared.
  function automatic int unsigned width_of(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  localparam int unsigned DEF_H_CNT_W = width_of(DEF_H_TOTAL);
  localparam int unsigned DEF_V_CNT_W = width_of(DEF_V_TOTAL);

endpackage

// File: rtl/vga_wrap_cnt.sv
// Modulo-MODULUS up-counter with synchronous clear and terminal-count flag.
// Latency: count updates on the edge after inc; wrap is combinational.
// No backpressure: inc is a plain advance strobe, clear overrides inc.
//
// Ports:
//   clk    - clock, all logic on rising edge
//   rst    - synchronous active-high reset (count -> 0)
//   clear  - synchronous clear (count -> 0), takes priority over inc
//   inc    - advance by one this cycle
//   count  - current value, 0..MODULUS-1
//   wrap   - high when inc is set and count is at MODULUS-1, i.e. the
//            counter rolls over to 0 on the coming edge
module vga_wrap_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned MODULUS = 16,
  parameter int unsigned W       = width_of(MODULUS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Video timing sequencer: generates VGA_HS/VGA_VS/VGA_DE plus an early pixel request.
// Latency: pix_req/pix_x/pix_y lead VGA_DE by one clock; VGA_DE is 2 clocks after counters.
// No backpressure: enable is a level request, honoured only on frame boundaries.
//
// Ports:
//   sys_clk      - pixel clock, all logic on rising edge
//   sys_rst      - synchronous active-high reset
//   enable       - level request to run video
//   busy         - high while the sequencer is not idle
//   pix_req      - pixel request, one cycle ahead of VGA_DE
//   pix_x/pix_y  - coordinates of the requested pixel (0 when pix_req=0)
//   frame_start  - pulse together with pix_req for pixel (0,0)
//   frame_done   - pulse on the last clock of a frame (stage-1 aligned)
//   VGA_HS/VS/DE - sync and data enable, mutually aligned
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = DEF_HS_POL,
  parameter bit          VS_POL   = DEF_VS_POL
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic                            enable,
  output logic                            busy,
  output logic                            pix_req,
  output logic [width_of(H_ACTIVE)-1:0]   pix_x,
  output logic [width_of(V_ACTIVE)-1:0]   pix_y,
  output logic                            frame_start,
  output logic                            frame_done,
  output logic                            VGA_HS,
  output logic                            VGA_VS,
  output logic                            VGA_DE
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = width_of(H_TOTAL);
  localparam int unsigned VW      = width_of(V_TOTAL);
  localparam int unsigned XW      = width_of(H_ACTIVE);
  localparam int unsigned YW      = width_of(V_ACTIVE);

  // Sync windows as half-open ranges [START, STOP). Kept as 32-bit constants
  // so that STOP may equal the total without overflowing the counter width.
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_STOP  = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_STOP  = VS_START + V_SYNC;

  // ------------------------------------------------------------------
  // Sequencer FSM
  // ------------------------------------------------------------------
  state_t state;
  state_t state_nxt;
  logic   running;      // counters advance in RUN and STOPPING
  logic   cnt_clear;    // hold/force counters to the frame origin

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap; // last clock of the frame while running

  assign running = (state != IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    case (state)
      IDLE: begin
        // Counters are already at (0,0), so the first RUN clock is pixel (0,0).
        if (enable) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = STOPPING;
        end
      end
      STOPPING: begin
        // A re-raised enable wins over the frame end, so back-to-back frames
        // continue without a gap.
        if (enable) begin
          state_nxt = RUN;
        end else if (v_wrap) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (state_nxt == IDLE) begin
      cnt_clear = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Stage 0: horizontal and vertical counters
  // ------------------------------------------------------------------
  vga_wrap_cnt #(
    .MODULUS (H_TOTAL),
    .W       (HW)
  ) u_h_cnt (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clear (cnt_clear),
    .inc   (running),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_wrap_cnt #(
    .MODULUS (V_TOTAL),
    .W       (VW)
  ) u_v_cnt (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clear (cnt_clear),
    .inc   (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  // Zero-extended copies for unsigned compares against 32-bit constants.
  logic [31:0] h_pos;
  logic [31:0] v_pos;
  logic        active;
  logic        hs_on;
  logic        vs_on;
  logic        at_origin;

  assign h_pos     = 32'(h_cnt);
  assign v_pos     = 32'(v_cnt);
  assign active    = running && (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
  assign hs_on     = running && (h_pos >= HS_START) && (h_pos < HS_STOP);
  assign vs_on     = running && (v_pos >= VS_START) && (v_pos < VS_STOP);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  // ------------------------------------------------------------------
  // Stage 1: pixel request, coordinates, frame markers
  // ------------------------------------------------------------------
  // hs_s1/vs_s1 carry the unpolarised "sync window" flag so HS/VS see the
  // same two-register delay as DE.
  logic hs_s1;
  logic vs_s1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      hs_s1       <= 1'b0;
      vs_s1       <= 1'b0;
    end else begin
      pix_req     <= active;
      pix_x       <= active ? XW'(h_cnt) : '0;
      pix_y       <= active ? YW'(v_cnt) : '0;
      frame_start <= active && at_origin;
      frame_done  <= v_wrap;
      // Registered so busy falls one clock after the FSM reaches IDLE,
      // i.e. after frame_done has been presented.
      busy        <= running;
      hs_s1       <= hs_on;
      vs_s1       <= vs_on;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: video timing outputs with sync polarity applied
  // ------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      VGA_DE <= 1'b0;
      VGA_HS <= ~HS_POL;
      VGA_VS <= ~VS_POL;
    end else begin
      VGA_DE <= pix_req;
      VGA_HS <= hs_s1 ? HS_POL : ~HS_POL;
      VGA_VS <= vs_s1 ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a 16x8 timing (H 8/2/3/3, V 4/1/2/1).
// Two instances share stimulus: one with active-high syncs, one active-low.
// Expected outputs come from the frame position implied by the start edge.
module tb_vga_timing_ctrl;

  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic       busy, pix_req, fs, fd, hs, vs, de;
  logic [2:0] px;
  logic [1:0] py;
  logic       busy_n, pix_req_n, fs_n, fd_n, hs_n, vs_n, de_n;
  logic [2:0] px_n;
  logic [1:0] py_n;

  vga_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .enable(en), .busy(busy),
    .pix_req(pix_req), .pix_x(px), .pix_y(py),
    .frame_start(fs), .frame_done(fd),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .sys_clk(clk), .sys_rst(rst), .enable(en), .busy(busy_n),
    .pix_req(pix_req_n), .pix_x(px_n), .pix_y(py_n),
    .frame_start(fs_n), .frame_done(fd_n),
    .VGA_HS(hs_n), .VGA_VS(vs_n), .VGA_DE(de_n)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int last_pos = BIG;   // last counter position of the current session
  int de_cnt   = 0;
  int fd_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // t = edges since the edge that sampled enable=1 in IDLE (t=0 is that edge).
  // After edge t, stage 1 shows counter position t-1 and stage 2 position t-2.
  task automatic check(input int t);
    bit ok1, ok2, req, de_e, hs_a, vs_a, fd_e, fs_e;
    int h1, v1, h2, v2;
    ok1 = (t >= 1) && (t - 1 <= last_pos);
    ok2 = (t >= 2) && (t - 2 <= last_pos);
    h1 = 0; v1 = 0; h2 = 0; v2 = 0;
    if (ok1) begin
      h1 = (t - 1) % 16;
      v1 = ((t - 1) / 16) % 8;
    end
    if (ok2) begin
      h2 = (t - 2) % 16;
      v2 = ((t - 2) / 16) % 8;
    end
    req  = ok1 && (h1 < 8) && (v1 < 4);
    fs_e = req && (h1 == 0) && (v1 == 0);
    fd_e = ok1 && (h1 == 15) && (v1 == 7);
    de_e = ok2 && (h2 < 8) && (v2 < 4);
    hs_a = ok2 && (h2 >= 10) && (h2 < 13);
    vs_a = ok2 && (v2 >= 5) && (v2 < 7);

    chk("pix_req", pix_req, req);
    chk("pix_x", px, req ? h1 : 0);
    chk("pix_y", py, req ? v1 : 0);
    chk("frame_start", fs, fs_e);
    chk("frame_done", fd, fd_e);
    chk("vga_de", de, de_e);
    chk("vga_hs", hs, hs_a);
    chk("vga_vs", vs, vs_a);
    chk("vga_de_n", de_n, de_e);
    chk("vga_hs_n", hs_n, !hs_a);
    chk("vga_vs_n", vs_n, !vs_a);
    if (t >= 1 && t <= last_pos) begin
      chk("busy_run", busy, 1);
    end else if (t >= last_pos + 2) begin
      chk("busy_idle", busy, 0);
    end
    if (de === 1'b1) de_cnt++;
    if (fd === 1'b1) fd_cnt++;
  endtask

  task automatic run(input int t_from, input int t_to);
    for (int t = t_from; t <= t_to; t++) begin
      @(posedge clk);
      #1;
      check(t);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pix_req"}, pix_req, 0);
    chk({tag, "_pix_x"}, px, 0);
    chk({tag, "_pix_y"}, py, 0);
    chk({tag, "_frame_start"}, fs, 0);
    chk({tag, "_frame_done"}, fd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_hs"}, hs, 0);
    chk({tag, "_vs"}, vs, 0);
    chk({tag, "_hs_n"}, hs_n, 1);
    chk({tag, "_vs_n"}, vs_n, 1);
    chk({tag, "_busy_n"}, busy_n, 0);
  endtask

  initial begin
    // Reset with enable already requested.
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");

    // Session 1: start on the first edge after reset release, two full frames.
    last_pos = BIG;
    rst = 1'b0;
    run(0, 257);

    // Drop enable in line 2 of the third frame; that frame must complete.
    de_cnt = 0;
    fd_cnt = 0;
    run(258, 291);
    en = 1'b0;
    last_pos = 383;
    run(292, 400);
    chk("stop_frame_de_pixels", de_cnt, 32);
    chk("stop_frame_done_pulses", fd_cnt, 1);

    // Session 2: restart from IDLE, drop and re-raise enable inside frame 0.
    en = 1'b1;
    last_pos = BIG;
    run(0, 50);
    en = 1'b0;
    run(51, 100);
    en = 1'b1;
    run(101, 300);
    chk("hs_high_before_reset", hs, 1);

    // Reset while the horizontal sync pulse is active.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("mid_reset");

    // Session 3: restart after reset with enable still high.
    rst = 1'b0;
    last_pos = BIG;
    run(0, 140);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
